french_tick_gen: RTL and testbench
==================================

FRENCH_TICK_GEN -- requirements
Module: french_tick_gen

Interface
REQ-001 The block SHALL have parameter TICK_BASE, default 500000, meaning the tick period in clock cycles at speed_level 0 (legal range 16..2^20-1).
REQ-002 The block SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR reset value (must be non-zero).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows.
REQ-004 CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 RESETn  input  1  asynchronous, active-low reset.
REQ-006 start_game  input  1  single-cycle request to leave IDLE.
REQ-007 pause  input  1  level; while 1 in RUN, the tick stream freezes.
REQ-008 game_over  input  1  single-cycle request to return to IDLE.
REQ-009 speed_level  input  2  period divisor select: period = TICK_BASE >> speed_level.
REQ-010 timer_done  output  1  one-cycle move strobe to the mover.
REQ-011 random  output  16  direction code for the mover; bits [15:4] always 0, bits [3:0] random.
REQ-012 tick_count  output  16  number of strobes issued since the last start, wrapping.
REQ-013 running  output  1  1 in RUN, 0 in IDLE and PAUSE.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, RUN and PAUSE.
REQ-015 IDLE->RUN SHALL occur on start_game=1; in the same edge, tick_count SHALL clear to 0 and the prescaler SHALL load P-1.
REQ-016 RUN->PAUSE SHALL occur on pause=1, and PAUSE->RUN SHALL occur on pause=0.
REQ-017 RUN or PAUSE ->IDLE SHALL occur on game_over=1.
REQ-018 Priority SHALL be game_over > pause > start_game; start_game in RUN or PAUSE SHALL be ignored.
REQ-019 The LFSR SHALL be a 16-bit Galois LFSR with polynomial mask 16'hB400, shifted right every cycle in every state; free-running mixes player timing into the sequence.
REQ-020 If the LFSR ever holds 0, it SHALL reload LFSR_SEED on the next edge.
REQ-021 The prescaler SHALL be a 20-bit down-counter, active only in RUN.
REQ-022 In PAUSE the prescaler SHALL hold its value, and counting SHALL resume from that value on return to RUN.
REQ-023 When the prescaler equals 0 in RUN, timer_done SHALL be 1 for exactly that cycle.
REQ-024 On the edge following a prescaler value of 0, the prescaler SHALL reload P-1, where P = TICK_BASE >> speed_level.
REQ-025 speed_level SHALL be sampled only at reload or at start; changes between reloads SHALL take effect on the next period.
REQ-026 Tick spacing in RUN SHALL be exactly P cycles, and the first strobe SHALL assert P cycles after the start edge.
REQ-027 random SHALL be registered and SHALL be updated to {12'b0, lfsr[3:0]} on the same edge that raises timer_done.
REQ-028 random SHALL stay stable during the timer_done cycle and until the next strobe; it SHALL never change while timer_done=0.
REQ-029 tick_count SHALL increment by 1 on each timer_done cycle, wrapping 16'hFFFF->0.
REQ-030 In IDLE, timer_done SHALL be 0, the prescaler SHALL hold P-1, and tick_count SHALL hold its last value.
REQ-031 If game_over coincides with prescaler=0, timer_done SHALL still assert in that cycle, and the state SHALL be IDLE afterward.
REQ-032 If pause rises in the prescaler=0 cycle, that strobe SHALL still be issued.
REQ-033 timer_done, random, running and tick_count SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-034 While RESETn=0, regardless of clock, the state SHALL be IDLE.
REQ-035 While RESETn=0: timer_done=0, random=0, tick_count=0, running=0, lfsr=LFSR_SEED, prescaler=TICK_BASE-1.
REQ-036 Reset asserted mid-RUN SHALL abort immediately; no strobe SHALL be issued during or on the first edge after RESETn deassertion.
REQ-037 After reset, start_game SHALL be required before any strobe.

Verification (TICK_BASE=16)
REQ-038 Scenario: reset, speed_level=0, pulse start_game at edge E -> timer_done high only at cycles E+16, E+32, E+48; tick_count=1,2,3; running=1.
REQ-039 Scenario: speed_level=2 in RUN -> after the current period, spacing becomes 4 cycles; speed_level=3 -> spacing 2.
REQ-040 Scenario: pause=1 for 10 cycles at prescaler=5 -> no strobes, prescaler held at 5, running=0; pause=0 -> next strobe 5 cycles later.
REQ-041 Scenario: 1000 strobes -> random[15:4]=0 at every strobe, random changes only on strobe edges, and all 16 nibble values occur.
REQ-042 Scenario: game_over and pause together at prescaler=0 -> timer_done=1 that cycle, then IDLE, running=0, no further strobes until start_game.
REQ-043 Scenario: RESETn pulsed low mid-period -> outputs zero at once; the LFSR sequence after reset matches the sequence from the first reset.

Source files
------------

// File: rtl/french_tick_gen.sv
// Game tick generator: a speed-scaled prescaler issues move strobes in RUN, each carrying a
// random 4-bit direction code from a free-running Galois LFSR.
module french_tick_gen #(
    parameter int unsigned TICK_BASE = 500000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start_game,
    input  logic        pause,
    input  logic        game_over,
    input  logic [1:0]  speed_level,
    output logic        timer_done,
    output logic [15:0] random,
    output logic [15:0] tick_count,
    output logic        running
);

    localparam int unsigned PW = 20;
    localparam int unsigned LW = 16;
    localparam int unsigned CW = 16;

    localparam logic [PW-1:0] BASE      = PW'(TICK_BASE);
    localparam logic [LW-1:0] LFSR_MASK = 16'hB400;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_q,  state_d;
    logic [PW-1:0] presc_q,  presc_d;
    logic [LW-1:0] lfsr_q,   lfsr_d;
    logic [15:0]   random_q, random_d;
    logic [CW-1:0] tick_q,   tick_d;
    logic          done_q,   done_d;
    logic          run_q,    run_d;
    logic [PW-1:0] reload_val;

    // Period for the currently selected speed, minus one (prescaler counts P-1 .. 0).
    assign reload_val = (BASE >> speed_level) - PW'(1);

    // Next-state, prescaler, LFSR and output-register logic.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        random_d = random_q;
        tick_d   = tick_q;
        done_d   = 1'b0;
        lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : LW'(0));

        if (lfsr_q == LW'(0)) begin
            lfsr_d = LFSR_SEED;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_game) begin
                    state_d = ST_RUN;
                    presc_d = reload_val;
                    tick_d  = CW'(0);
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
                // A terminal count is honoured even if the game ends or pauses in that cycle.
                if (presc_q == PW'(0)) begin
                    done_d   = 1'b1;
                    random_d = {12'b0, lfsr_q[3:0]};
                    tick_d   = tick_q + CW'(1);
                end
                if (game_over || presc_q == PW'(0)) begin
                    presc_d = reload_val;
                end else begin
                    presc_d = presc_q - PW'(1);
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d = ST_IDLE;
                    presc_d = reload_val;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = reload_val;
            end
        endcase

        run_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            presc_q  <= BASE - PW'(1);
            lfsr_q   <= LFSR_SEED;
            random_q <= 16'h0000;
            tick_q   <= CW'(0);
            done_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            lfsr_q   <= lfsr_d;
            random_q <= random_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            run_q    <= run_d;
        end
    end

    assign timer_done = done_q;
    assign random     = random_q;
    assign tick_count = tick_q;
    assign running    = run_q;

endmodule

// File: tb/tb_french_tick_gen.sv
// Directed bench for french_tick_gen with TICK_BASE=16 (periods 16/8/4/2 per speed level).
module tb_french_tick_gen;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        start_game = 1'b0;
    logic        pause = 1'b0;
    logic        game_over = 1'b0;
    logic [1:0]  speed_level = 2'd0;
    logic        timer_done;
    logic [15:0] random;
    logic [15:0] tick_count;
    logic        running;

    int checks = 0;
    int errors = 0;

    french_tick_gen #(.TICK_BASE(16), .LFSR_SEED(16'hACE1)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .start_game (start_game),
        .pause      (pause),
        .game_over  (game_over),
        .speed_level(speed_level),
        .timer_done (timer_done),
        .random     (random),
        .tick_count (tick_count),
        .running    (running)
    );

    always #5 CLK = ~CLK;

    // Reference LFSR: m_prev is the register value during the cycle before the latest edge.
    logic [15:0] m_lfsr, m_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0000) return 16'hACE1;
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_game = 1'b1;
        step(1);
        start_game = 1'b0;
    endtask

    task automatic go_idle();
        game_over = 1'b1;
        pause     = 1'b0;
        step(1);
        game_over = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        start_game = 1'b1;
        step(3);
        checks++; if (timer_done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", timer_done); end
        checks++; if (random !== 16'h0) begin errors++; $display("FAIL rst_random got %0h exp 0", random); end
        checks++; if (tick_count !== 16'h0) begin errors++; $display("FAIL rst_count got %0h exp 0", tick_count); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %0b exp 0", running); end
        start_game = 1'b0;
        RESETn = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            checks++;
            if (timer_done !== 1'b0 || running !== 1'b0) begin
                errors++; $display("FAIL idle_after_rst cycle %0d done %0b run %0b exp 0 0", k, timer_done, running);
            end
        end
    endtask

    task automatic test_basic();
        speed_level = 2'd0;
        pulse_start();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %0b exp 1", running); end
        checks++; if (tick_count !== 16'h0) begin errors++; $display("FAIL start_count got %0h exp 0", tick_count); end
        for (int k = 1; k <= 48; k++) begin
            logic exp_d;
            step(1);
            exp_d = (k % 16 == 0);
            checks++;
            if (timer_done !== exp_d) begin
                errors++; $display("FAIL basic_strobe cycle %0d got %0b exp %0b", k, timer_done, exp_d);
            end
            if (k % 16 == 0) begin
                checks++;
                if (tick_count !== 16'(k / 16)) begin
                    errors++; $display("FAIL basic_count cycle %0d got %0d exp %0d", k, tick_count, k / 16);
                end
            end
            // A start request while running must not restart the period or the count.
            start_game = (k == 20);
        end
        start_game = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running got %0b exp 1", running); end
    endtask

    task automatic test_speed();
        go_idle();
        speed_level = 2'd0;
        pulse_start();
        speed_level = 2'd2;
        for (int k = 1; k <= 32; k++) begin
            logic exp_d;
            step(1);
            exp_d = (k == 16 || k == 20 || k == 24 || k == 28 || k == 30 || k == 32);
            checks++;
            if (timer_done !== exp_d) begin
                errors++; $display("FAIL speed_strobe cycle %0d got %0b exp %0b", k, timer_done, exp_d);
            end
            if (k == 24) speed_level = 2'd3;
        end
        checks++; if (tick_count !== 16'd6) begin errors++; $display("FAIL speed_count got %0d exp 6", tick_count); end
    endtask

    task automatic test_pause();
        go_idle();
        speed_level = 2'd0;
        pulse_start();
        step(10);
        pause = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if (timer_done !== 1'b0 || running !== 1'b0) begin
                errors++; $display("FAIL pause_hold cycle %0d done %0b run %0b exp 0 0", k, timer_done, running);
            end
        end
        pause = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            logic exp_d;
            step(1);
            exp_d = (j == 6);
            checks++;
            if (timer_done !== exp_d || running !== 1'b1) begin
                errors++; $display("FAIL pause_resume cycle %0d done %0b run %0b exp %0b 1", j, timer_done, running, exp_d);
            end
        end
        checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL pause_count got %0d exp 1", tick_count); end
    endtask

    task automatic test_random();
        logic [15:0] prev_rand;
        logic [15:0] seen;
        int strobes;
        go_idle();
        speed_level = 2'd3;
        pulse_start();
        prev_rand = random;
        seen = 16'h0;
        strobes = 0;
        for (int c = 0; c < 2200 && strobes < 1000; c++) begin
            step(1);
            checks++;
            if (timer_done) begin
                strobes++;
                if (random !== {12'h000, m_prev[3:0]}) begin
                    errors++; $display("FAIL rand_value strobe %0d got %0h exp %0h", strobes, random, {12'h000, m_prev[3:0]});
                end
                seen[random[3:0]] = 1'b1;
            end else if (random !== prev_rand) begin
                errors++; $display("FAIL rand_stable cycle %0d got %0h exp %0h", c, random, prev_rand);
            end
            prev_rand = random;
        end
        checks++; if (strobes != 1000) begin errors++; $display("FAIL rand_strobes got %0d exp 1000", strobes); end
        checks++; if (seen !== 16'hFFFF) begin errors++; $display("FAIL rand_coverage got %0h exp ffff", seen); end
        checks++; if (tick_count !== 16'd1000) begin errors++; $display("FAIL rand_count got %0d exp 1000", tick_count); end
    endtask

    task automatic test_gameover_pause();
        go_idle();
        speed_level = 2'd0;
        pulse_start();
        step(15);
        game_over = 1'b1;
        pause     = 1'b1;
        step(1);
        game_over = 1'b0;
        pause     = 1'b0;
        checks++; if (timer_done !== 1'b1) begin errors++; $display("FAIL go_strobe got %0b exp 1", timer_done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL go_running got %0b exp 0", running); end
        checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL go_count got %0d exp 1", tick_count); end
        for (int k = 1; k <= 40; k++) begin
            step(1);
            checks++;
            if (timer_done !== 1'b0 || running !== 1'b0) begin
                errors++; $display("FAIL go_idle cycle %0d done %0b run %0b exp 0 0", k, timer_done, running);
            end
        end
        checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL go_hold_count got %0d exp 1", tick_count); end
        pulse_start();
        checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL go_restart_count got %0d exp 0", tick_count); end
    endtask

    task automatic test_reset_midrun();
        go_idle();
        speed_level = 2'd0;
        pulse_start();
        step(20);
        #2;
        RESETn = 1'b0;
        #1;
        checks++; if (timer_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %0b exp 0", timer_done); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_rst_running got %0b exp 0", running); end
        checks++; if (tick_count !== 16'h0) begin errors++; $display("FAIL mid_rst_count got %0h exp 0", tick_count); end
        checks++; if (random !== 16'h0) begin errors++; $display("FAIL mid_rst_random got %0h exp 0", random); end
        step(2);
        RESETn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++;
            if (timer_done !== 1'b0 || running !== 1'b0) begin
                errors++; $display("FAIL mid_rst_idle cycle %0d done %0b run %0b exp 0 0", k, timer_done, running);
            end
        end
        pulse_start();
        for (int k = 1; k <= 32; k++) begin
            step(1);
            checks++;
            if (timer_done !== (k % 16 == 0)) begin
                errors++; $display("FAIL mid_rst_strobe cycle %0d got %0b exp %0b", k, timer_done, (k % 16 == 0));
            end
            if (timer_done) begin
                checks++;
                if (random !== {12'h000, m_prev[3:0]}) begin
                    errors++; $display("FAIL mid_rst_random_seq cycle %0d got %0h exp %0h", k, random, {12'h000, m_prev[3:0]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_speed();
        test_pause();
        test_random();
        test_gameover_pause();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
